// File: rtl/vending_pkg.sv
// Shared types and code constants for the 15-unit single-product coin acceptor.
package vending_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;

    localparam logic [1:0] CHG_NONE  = 2'd0;
    localparam logic [1:0] CHG_5     = 2'd1;
    localparam logic [1:0] CHG_10    = 2'd2;

endpackage

// File: rtl/vending_machine.sv
// Coin acceptor: one coin code per clock, registered dispense pulse and change code.
//
// state | meaning
// S0    | no credit
// S1    | 5 units credited
// S2    | 10 units credited
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    state_t     state;
    state_t     nxt_state;
    logic       nxt_out;
    logic [1:0] nxt_change;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S0;
            out    <= 1'b0;
            change <= CHG_NONE;
        end else begin
            state  <= nxt_state;
            out    <= nxt_out;
            change <= nxt_change;
        end
    end

    // An empty coin slot while credit is held is a cancel and refunds the credit.
    always_comb begin
        nxt_state  = state;
        nxt_out    = 1'b0;
        nxt_change = CHG_NONE;
        case (state)
            S0: begin
                case (in)
                    COIN_NONE: nxt_state = S0;
                    COIN_5:    nxt_state = S1;
                    COIN_10:   nxt_state = S2;
                    default:   nxt_state = S0;
                endcase
            end
            S1: begin
                case (in)
                    COIN_NONE: begin
                        nxt_state  = S0;
                        nxt_change = CHG_5;
                    end
                    COIN_5:    nxt_state = S2;
                    COIN_10: begin
                        nxt_state = S0;
                        nxt_out   = 1'b1;
                    end
                    default:   nxt_state = S1;
                endcase
            end
            S2: begin
                case (in)
                    COIN_NONE: begin
                        nxt_state  = S0;
                        nxt_change = CHG_10;
                    end
                    COIN_5: begin
                        nxt_state = S0;
                        nxt_out   = 1'b1;
                    end
                    COIN_10: begin
                        nxt_state  = S0;
                        nxt_out    = 1'b1;
                        nxt_change = CHG_5;
                    end
                    default:   nxt_state = S2;
                endcase
            end
            default: begin
                nxt_state  = S0;
                nxt_out    = 1'b0;
                nxt_change = CHG_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_vending_machine.sv
// Directed and random checks of vending_machine against a credit-arithmetic model.
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    int errors = 0;
    int checks = 0;
    int credit = 0;
    logic       exp_out;
    logic [1:0] exp_change;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: credit in units, sale at >= 15, change is the excess in 5-unit steps.
    task automatic model(input logic r, input logic [1:0] c);
        int val;
        if (r) begin
            credit     = 0;
            exp_out    = 1'b0;
            exp_change = 2'd0;
        end else if (c == 2'd3) begin
            exp_out    = 1'b0;
            exp_change = 2'd0;
        end else if (c == 2'd0) begin
            exp_out    = 1'b0;
            exp_change = 2'(credit / 5);
            credit     = 0;
        end else begin
            val    = (c == 2'd1) ? 5 : 10;
            credit = credit + val;
            if (credit >= 15) begin
                exp_out    = 1'b1;
                exp_change = 2'((credit - 15) / 5);
                credit     = 0;
            end else begin
                exp_out    = 1'b0;
                exp_change = 2'd0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input string tag);
        @(negedge clk);
        rst = r;
        in  = c;
        @(posedge clk);
        model(r, c);
        #1;
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: observed=%0b expected=%0b", tag, out, exp_out);
        end
        checks++;
        assert (change === exp_change) else begin
            errors++;
            $error("FAIL %s change: observed=%0d expected=%0d", tag, change, exp_change);
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = 2'd0;

        step(1'b1, 2'd2, "reset0");
        step(1'b1, 2'd2, "reset1");

        step(1'b0, 2'd1, "555_a");
        step(1'b0, 2'd1, "555_b");
        step(1'b0, 2'd1, "555_c");
        step(1'b0, 2'd0, "555_idle");

        step(1'b0, 2'd1, "5_10_a");
        step(1'b0, 2'd2, "5_10_b");
        step(1'b0, 2'd0, "5_10_idle");

        step(1'b0, 2'd2, "10_10_a");
        step(1'b0, 2'd2, "10_10_b");
        step(1'b0, 2'd0, "10_10_idle");

        step(1'b0, 2'd1, "cancel5_a");
        step(1'b0, 2'd0, "cancel5_b");
        step(1'b0, 2'd0, "cancel5_s0");
        step(1'b0, 2'd2, "cancel10_a");
        step(1'b0, 2'd0, "cancel10_b");
        step(1'b0, 2'd0, "cancel10_s0");

        step(1'b0, 2'd2, "illegal_a");
        step(1'b0, 2'd3, "illegal_b");
        step(1'b0, 2'd1, "illegal_c");

        step(1'b0, 2'd2, "rstmid_a");
        step(1'b1, 2'd0, "rstmid_b");
        step(1'b0, 2'd1, "rstmid_c");
        step(1'b0, 2'd0, "rstmid_d");

        // Sale followed immediately by a new coin, no idle cycle between.
        step(1'b0, 2'd2, "b2b_a");
        step(1'b0, 2'd1, "b2b_b");
        step(1'b0, 2'd2, "b2b_c");
        step(1'b0, 2'd2, "b2b_d");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
